// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 64-bit mtime/mtimecmp timer with a level interrupt.
// Register reads and writes complete one cycle after the request.
// Optional feature: define BUS_TIMER_PRESCALE_EN to add a 16-bit tick prescaler.
module bus_timer #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    device_req_i,
    input  logic [AddressWidth-1:0] device_addr_i,
    input  logic                    device_we_i,
    input  logic [DataWidth-1:0]    device_wdata_i,
    output logic [DataWidth-1:0]    device_rdata_o,
    output logic                    device_rvalid_o,
    output logic                    timer_irq_o
);

    localparam logic [2:0] RegMtimeLo    = 3'd0;
    localparam logic [2:0] RegMtimeHi    = 3'd1;
    localparam logic [2:0] RegMtimecmpLo = 3'd2;
    localparam logic [2:0] RegMtimecmpHi = 3'd3;
    localparam logic [2:0] RegCtrl       = 3'd4;
    localparam logic [2:0] RegStatus     = 3'd5;
    localparam logic [2:0] RegPrescale   = 3'd6;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        count_en_q, count_en_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q;
    logic        irq_q;

    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;
    logic        inc_en;
    logic        mtime_ge;
    logic [31:0] prescale_rd;
    logic [31:0] rd_val;

    // Only addr[4:2] selects a register; the rest is don't-care.
    logic unused_addr;
    assign unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};

    assign reg_sel  = device_addr_i[4:2];
    assign wr_en    = device_req_i & device_we_i;
    assign rd_en    = device_req_i & ~device_we_i;
    assign mtime_ge = (mtime_q >= mtimecmp_q);

`ifdef BUS_TIMER_PRESCALE_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] psc_cnt_q, psc_cnt_d;

    assign inc_en      = count_en_q && (psc_cnt_q == prescale_q);
    assign prescale_rd = {16'd0, prescale_q};

    // Prescale divider: wraps on a tick, restarts whenever PRESCALE is rewritten.
    always_comb begin
        prescale_d = prescale_q;
        psc_cnt_d  = psc_cnt_q;
        if (count_en_q) begin
            psc_cnt_d = inc_en ? 16'd0 : psc_cnt_q + 16'd1;
        end
        if (wr_en && (reg_sel == RegPrescale)) begin
            prescale_d = device_wdata_i[15:0];
            psc_cnt_d  = 16'd0;
        end
    end

    // Prescale state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prescale_q <= 16'd0;
            psc_cnt_q  <= 16'd0;
        end else begin
            prescale_q <= prescale_d;
            psc_cnt_q  <= psc_cnt_d;
        end
    end
`else
    assign inc_en      = count_en_q;
    assign prescale_rd = 32'd0;
`endif

    // Read mux on pre-update register contents.
    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            RegMtimeLo:    rd_val = mtime_q[31:0];
            RegMtimeHi:    rd_val = shadow_q;
            RegMtimecmpLo: rd_val = mtimecmp_q[31:0];
            RegMtimecmpHi: rd_val = mtimecmp_q[63:32];
            RegCtrl:       rd_val = {30'd0, irq_en_q, count_en_q};
            RegStatus:     rd_val = {31'd0, mtime_ge};
            RegPrescale:   rd_val = prescale_rd;
            default:       rd_val = 32'd0;
        endcase
    end

    // Next-state: counting, bus writes (which beat the increment), shadow capture.
    always_comb begin
        mtime_d    = inc_en ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        count_en_d = count_en_q;
        irq_en_d   = irq_en_q;
        shadow_d   = shadow_q;
        rdata_d    = rdata_q;

        if (rd_en && (reg_sel == RegMtimeLo)) begin
            shadow_d = mtime_q[63:32];
        end

        if (wr_en) begin
            case (reg_sel)
                RegMtimeLo: mtime_d = {mtime_q[63:32], device_wdata_i};
                RegMtimeHi: begin
                    mtime_d  = {device_wdata_i, mtime_q[31:0]};
                    shadow_d = device_wdata_i;
                end
                RegMtimecmpLo: mtimecmp_d = {mtimecmp_q[63:32], device_wdata_i};
                RegMtimecmpHi: mtimecmp_d = {device_wdata_i, mtimecmp_q[31:0]};
                RegCtrl: begin
                    count_en_d = device_wdata_i[0];
                    irq_en_d   = device_wdata_i[1];
                end
                default: ;
            endcase
        end

        if (device_req_i) begin
            rdata_d = device_we_i ? 32'd0 : rd_val;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            count_en_q <= 1'b0;
            irq_en_q   <= 1'b0;
            shadow_q   <= 32'd0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            count_en_q <= count_en_d;
            irq_en_q   <= irq_en_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= device_req_i;
            irq_q      <= irq_en_q & mtime_ge;
        end
    end

    assign device_rdata_o  = rdata_q;
    assign device_rvalid_o = rvalid_q;
    assign timer_irq_o     = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed and random bus traffic checked against a behavioural model.
module tb_bus_timer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        device_req_i = 1'b0;
    logic [31:0] device_addr_i = '0;
    logic        device_we_i = 1'b0;
    logic [31:0] device_wdata_i = '0;
    logic [31:0] device_rdata_o;
    logic        device_rvalid_o;
    logic        timer_irq_o;

    bus_timer #(
        .DataWidth   (32),
        .AddressWidth(32)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .device_req_i   (device_req_i),
        .device_addr_i  (device_addr_i),
        .device_we_i    (device_we_i),
        .device_wdata_i (device_wdata_i),
        .device_rdata_o (device_rdata_o),
        .device_rvalid_o(device_rvalid_o),
        .timer_irq_o    (timer_irq_o)
    );

    always #5 clk_i = ~clk_i;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "init";

    // Reference model state: the architectural registers as plain integers.
    logic [63:0] m_mtime = '0;
    logic [63:0] m_cmp = '1;
    bit          m_cen = 0;
    bit          m_ien = 0;
    int unsigned m_psc = 0;
    int unsigned m_div = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_rdata = '0;
    bit          m_rvalid = 0;
    bit          m_irq = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] sel);
        case (sel)
            3'd0: return m_mtime[31:0];
            3'd1: return m_shadow;
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_ien, m_cen};
            3'd5: return (m_mtime >= m_cmp) ? 32'd1 : 32'd0;
`ifdef BUS_TIMER_PRESCALE_EN
            3'd6: return m_psc & 32'hFFFF;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the peripheral as the register map describes it.
    task automatic model_step(input bit rst_n, input bit req, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        logic [2:0]  sel;
        logic [63:0] old_mtime;
        bit          tick;
        bit          irq_n;
        if (!rst_n) begin
            m_mtime = '0; m_cmp = '1; m_cen = 0; m_ien = 0; m_psc = 0; m_div = 0;
            m_shadow = '0; m_rdata = '0; m_rvalid = 0; m_irq = 0;
            return;
        end
        sel       = addr[4:2];
        old_mtime = m_mtime;
        irq_n     = m_ien && (m_mtime >= m_cmp);
        m_rvalid  = req;
        if (req) m_rdata = we ? 32'd0 : model_read(sel);
`ifdef BUS_TIMER_PRESCALE_EN
        // mtime advances on every (PRESCALE+1)-th enabled cycle.
        tick = m_cen && (m_div == m_psc);
        if (m_cen) m_div = tick ? 0 : m_div + 1;
`else
        tick = m_cen;
`endif
        if (tick) m_mtime = old_mtime + 64'd1;
        if (req && !we && sel == 3'd0) m_shadow = old_mtime[63:32];
        if (req && we) begin
            case (sel)
                3'd0: m_mtime = {old_mtime[63:32], wdata};
                3'd1: begin m_mtime = {wdata, old_mtime[31:0]}; m_shadow = wdata; end
                3'd2: m_cmp[31:0] = wdata;
                3'd3: m_cmp[63:32] = wdata;
                3'd4: begin m_cen = wdata[0]; m_ien = wdata[1]; end
`ifdef BUS_TIMER_PRESCALE_EN
                3'd6: begin m_psc = wdata & 32'hFFFF; m_div = 0; end
`endif
                default: ;
            endcase
        end
        m_irq = irq_n;
    endtask

    // Drive one cycle from the falling edge, then compare outputs on the next falling edge.
    task automatic cycle(input bit rst_n, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        rst_ni         = rst_n;
        device_req_i   = req;
        device_we_i    = we;
        device_addr_i  = addr;
        device_wdata_i = wdata;
        @(posedge clk_i);
        model_step(rst_n, req, we, addr, wdata);
        @(negedge clk_i);
        check("rvalid", device_rvalid_o, m_rvalid);
        check("rdata", device_rdata_o, m_rdata);
        check("irq", timer_irq_o, m_irq);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        cycle(1, 1, 1, addr, data);
    endtask

    task automatic rd(input logic [31:0] addr);
        cycle(1, 1, 0, addr, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          k;
        @(negedge clk_i);

        phase = "reset";
        cycle(0, 1, 0, 32'h0, 32'h0);  // request during reset must be dropped
        cycle(0, 0, 0, 32'h0, 32'h0);
        check("rst_rvalid", device_rvalid_o, 0);
        check("rst_irq", timer_irq_o, 0);
        rd(32'h00); check("rd_lo", device_rdata_o, 32'h0); check("rd_lo_v", device_rvalid_o, 1);
        rd(32'h04); check("rd_hi", device_rdata_o, 32'h0);
        rd(32'h08); check("rd_cmp_lo", device_rdata_o, 32'hFFFF_FFFF);
        rd(32'h10); check("rd_ctrl", device_rdata_o, 32'h0);
        idle(1); check("rvalid_drop", device_rvalid_o, 0);

        phase = "count";
        wr(32'h10, 32'h1);
        idle(10);
        rd(32'h00); check("ten_cycles", device_rdata_o, 32'd10);

        phase = "carry";
        wr(32'h10, 32'h0);
        wr(32'h00, 32'hFFFF_FFFE);
        wr(32'h04, 32'h0);
        wr(32'h10, 32'h1);
        idle(3);
        rd(32'h00); check("carry_lo", device_rdata_o, 32'h1);
        rd(32'h04); check("carry_hi", device_rdata_o, 32'h1);
        wr(32'h00, 32'hFFFF_FFFF);
        wr(32'h04, 32'hFFFF_FFFF);
        idle(1);
        rd(32'h00); check("wrap_lo", device_rdata_o, 32'h0);
        rd(32'h04); check("wrap_hi", device_rdata_o, 32'h0);

        phase = "irq";
        wr(32'h10, 32'h0);
        wr(32'h00, 32'h0);
        wr(32'h04, 32'h0);
        wr(32'h08, 32'd20);
        wr(32'h0C, 32'h0);
        wr(32'h10, 32'h3);
        idle(20); check("irq_before", timer_irq_o, 0);
        idle(1);  check("irq_rise", timer_irq_o, 1);
        rd(32'h14); check("status_set", device_rdata_o, 32'h1);
        wr(32'h08, 32'd100); check("irq_hold", timer_irq_o, 1);
        idle(1); check("irq_fall", timer_irq_o, 0);
        rd(32'h14); check("status_clr", device_rdata_o, 32'h0);

        phase = "shadow";
        wr(32'h10, 32'h0);
        wr(32'h00, 32'hFFFF_FFFF);
        wr(32'h04, 32'h0);
        wr(32'h10, 32'h1);
        rd(32'h00); check("sh_lo", device_rdata_o, 32'hFFFF_FFFF);
        rd(32'h04); check("sh_hi", device_rdata_o, 32'h0);

`ifdef BUS_TIMER_PRESCALE_EN
        phase = "prescale";
        wr(32'h10, 32'h0);
        wr(32'h18, 32'd3);
        wr(32'h00, 32'h0);
        wr(32'h04, 32'h0);
        wr(32'h10, 32'h1);
        idle(7);
        rd(32'h00); check("psc_lo", device_rdata_o, 32'd1);
        idle(3);
        wr(32'h00, 32'h1234);  // lands on a tick
        rd(32'h00); check("psc_wr_tick", device_rdata_o, 32'h1234);
        rd(32'h18); check("psc_rd", device_rdata_o, 32'd3);
`else
        phase = "noprescale";
        wr(32'h18, 32'd3);
        rd(32'h18); check("psc_rd", device_rdata_o, 32'd0);
`endif

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            a = $urandom;
            a[4:2] = 3'($urandom_range(0, 7));
            k = int'(a[4:2]);
            if (k == 6) d = $urandom_range(0, 3) | ($urandom_range(0, 1) ? 32'hABCD_0000 : 32'h0);
            else if (k == 1 || k == 3) d = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
            else if ($urandom_range(0, 3) == 0) d = $urandom;
            else d = $urandom_range(0, 40);
            if ($urandom_range(0, 199) == 0)
                cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
            else
                cycle(1, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
